// File: rtl/sweep_counter.sv
`default_nettype none
// ============================================================================
// Module      : sweep_counter
// Description : Multi-axis sweep-enable terminal counter, one FSM per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_counter #(
  parameter int NCH    = 2,
  parameter int CW     = 5,
  parameter int MAXCNT = 31,
  parameter int MODE   = 0,
  parameter int REARM  = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NCH-1:0]      EN,
  input  logic [NCH-1:0]      PWM_LIMIT,
  output logic [NCH-1:0]      CNT_EN,
  output logic [NCH-1:0]      DONE,
  output logic [NCH*CW-1:0]   COUNT,
  output logic                BUSY
);

  localparam logic [1:0]    c_idle  = 2'd0;
  localparam logic [1:0]    c_run   = 2'd1;
  localparam logic [1:0]    c_stop  = 2'd2;
  localparam logic [CW-1:0] c_max   = CW'(MAXCNT);
  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic          c_force = (MODE != 0);
  localparam logic          c_hold  = (REARM != 0);

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [1:0]    r_state;
      logic [1:0]    w_state_nxt;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;
      logic          r_cnt_en;
      logic          w_cnt_en_nxt;
      logic          r_done;
      logic          w_done_nxt;
      logic          w_at_max;
      logic          w_term;

      // The limit flag only matters once the count sits on the terminal value.
      assign w_at_max = (r_cnt == c_max);
      assign w_term   = w_at_max && (PWM_LIMIT[i] || c_force);

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          r_state  <= c_idle;
          r_cnt    <= '0;
          r_cnt_en <= 1'b0;
          r_done   <= 1'b0;
        end else begin
          r_state  <= w_state_nxt;
          r_cnt    <= w_cnt_nxt;
          r_cnt_en <= w_cnt_en_nxt;
          r_done   <= w_done_nxt;
        end
      end

      always_comb begin
        w_state_nxt = c_idle;
        if (EN[i]) begin
          case (r_state)
            c_idle:  w_state_nxt = c_run;
            c_run:   w_state_nxt = w_term ? c_stop : c_run;
            c_stop:  w_state_nxt = c_hold ? c_stop : c_run;
            default: w_state_nxt = c_idle;
          endcase
        end
      end

      // Outputs are computed one cycle early so the ports come straight from flops.
      always_comb begin
        w_cnt_nxt    = '0;
        w_cnt_en_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        if (EN[i]) begin
          case (r_state)
            c_idle: begin
              w_cnt_en_nxt = 1'b1;
              w_cnt_nxt    = c_one;
            end
            c_run: begin
              if (w_term) begin
                w_done_nxt = 1'b1;
              end else begin
                w_cnt_en_nxt = 1'b1;
                w_cnt_nxt    = w_at_max ? '0 : (r_cnt + c_one);
              end
            end
            c_stop: begin
              if (!c_hold) begin
                w_cnt_en_nxt = 1'b1;
                w_cnt_nxt    = c_one;
              end
            end
            default: begin
              w_cnt_nxt    = '0;
              w_cnt_en_nxt = 1'b0;
              w_done_nxt   = 1'b0;
            end
          endcase
        end
      end

      assign CNT_EN[i]         = r_cnt_en;
      assign DONE[i]           = r_done;
      assign COUNT[i*CW +: CW] = r_cnt;
    end
  endgenerate

  assign BUSY = |CNT_EN;

endmodule
`default_nettype wire

// File: tb/tb_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_counter
// Description : Directed bench for sweep_counter over four parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_counter;

  localparam int NI = 4;
  localparam int P_MAX   [NI] = '{31, 31, 31, 20};
  localparam int P_MODE  [NI] = '{0, 0, 1, 0};
  localparam int P_REARM [NI] = '{1, 0, 1, 1};

  logic       clk;
  logic       rst_n;
  logic [1:0] en;
  logic [1:0] pwm;

  logic [1:0] d_cnt_en [NI];
  logic [1:0] d_done   [NI];
  logic [9:0] d_count  [NI];
  logic       d_busy   [NI];

  int  m_cnt  [NI][2];
  bit  m_on   [NI][2];
  bit  m_done [NI][2];
  bit  m_held [NI][2];

  int  n_checks;
  int  n_fail;
  bit  chk_on;
  int  done_n;
  int  low_n;

  string inst_name [NI] = '{"base", "rearm0", "mode1", "max20"};

  sweep_counter #(.NCH(2), .CW(5), .MAXCNT(31), .MODE(0), .REARM(1)) u_base (
    .CLK(clk), .RST_N(rst_n), .EN(en), .PWM_LIMIT(pwm),
    .CNT_EN(d_cnt_en[0]), .DONE(d_done[0]), .COUNT(d_count[0]), .BUSY(d_busy[0]));
  sweep_counter #(.NCH(2), .CW(5), .MAXCNT(31), .MODE(0), .REARM(0)) u_rearm0 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .PWM_LIMIT(pwm),
    .CNT_EN(d_cnt_en[1]), .DONE(d_done[1]), .COUNT(d_count[1]), .BUSY(d_busy[1]));
  sweep_counter #(.NCH(2), .CW(5), .MAXCNT(31), .MODE(1), .REARM(1)) u_mode1 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .PWM_LIMIT(pwm),
    .CNT_EN(d_cnt_en[2]), .DONE(d_done[2]), .COUNT(d_count[2]), .BUSY(d_busy[2]));
  sweep_counter #(.NCH(2), .CW(5), .MAXCNT(20), .MODE(0), .REARM(1)) u_max20 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .PWM_LIMIT(pwm),
    .CNT_EN(d_cnt_en[3]), .DONE(d_done[3]), .COUNT(d_count[3]), .BUSY(d_busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel model: idle -> counting from 1 -> stopped (held or rearmed).
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (!rst_n || !en[c]) begin
          m_cnt[k][c]  <= 0;
          m_on[k][c]   <= 1'b0;
          m_done[k][c] <= 1'b0;
          m_held[k][c] <= 1'b0;
        end else if (m_held[k][c]) begin
          m_done[k][c] <= 1'b0;
          if (P_REARM[k] == 0) begin
            m_held[k][c] <= 1'b0;
            m_on[k][c]   <= 1'b1;
            m_cnt[k][c]  <= 1;
          end
        end else if (!m_on[k][c]) begin
          m_on[k][c]   <= 1'b1;
          m_cnt[k][c]  <= 1;
          m_done[k][c] <= 1'b0;
        end else if (m_cnt[k][c] == P_MAX[k] && (pwm[c] || P_MODE[k] == 1)) begin
          m_on[k][c]   <= 1'b0;
          m_cnt[k][c]  <= 0;
          m_done[k][c] <= 1'b1;
          m_held[k][c] <= 1'b1;
        end else begin
          m_cnt[k][c]  <= (m_cnt[k][c] == P_MAX[k]) ? 0 : m_cnt[k][c] + 1;
          m_done[k][c] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        logic [4:0] e0;
        logic [4:0] e1;
        e0 = m_cnt[k][0][4:0];
        e1 = m_cnt[k][1][4:0];
        chk({inst_name[k], ".cnt_en"}, 32'(d_cnt_en[k]), 32'({m_on[k][1], m_on[k][0]}));
        chk({inst_name[k], ".done"},   32'(d_done[k]),   32'({m_done[k][1], m_done[k][0]}));
        chk({inst_name[k], ".count"},  32'(d_count[k]),  32'({e1, e0}));
        chk({inst_name[k], ".busy"},   32'(d_busy[k]),   32'(m_on[k][1] | m_on[k][0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_on   = 1'b0;
    rst_n    = 1'b0;
    en       = 2'b00;
    pwm      = 2'b00;
    tick(2);
    chk_on = 1'b1;
    chk("reset.count",  32'(d_count[0]),  32'd0);
    chk("reset.cnt_en", 32'(d_cnt_en[0]), 32'd0);
    chk("reset.done",   32'(d_done[0]),   32'd0);
    chk("reset.busy",   32'(d_busy[0]),   32'd0);

    // Free-running wrap with no limit
    rst_n = 1'b1;
    en    = 2'b01;
    tick(1);
    chk("t1.first_count", 32'(d_count[0][4:0]), 32'd1);
    chk("t1.first_en",    32'(d_cnt_en[0]),     32'b01);
    tick(39);
    chk("t1.count40",     32'(d_count[0][4:0]), 32'd8);
    chk("t1.cnt_en40",    32'(d_cnt_en[0]),     32'b01);
    chk("t1.busy40",      32'(d_busy[0]),       32'd1);
    chk("t1.max20_count", 32'(d_count[3][4:0]), 32'd19);
    chk("t1.mode1_stop",  32'(d_cnt_en[2]),     32'b00);

    // Limit stop and hold, then restart via EN low
    en = 2'b00; tick(1);
    en = 2'b01; pwm = 2'b01;
    tick(31);
    chk("t2.at_max",   32'(d_count[0][4:0]), 32'd31);
    tick(1);
    chk("t2.done",     32'(d_done[0]),   32'b01);
    chk("t2.stop_en",  32'(d_cnt_en[0]), 32'b00);
    chk("t2.stop_cnt", 32'(d_count[0]),  32'd0);
    tick(1);
    chk("t2.done_gone", 32'(d_done[0]),  32'b00);
    tick(5);
    chk("t2.held",     32'(d_cnt_en[0]), 32'b00);
    en = 2'b00; tick(1);
    en = 2'b01; tick(1);
    chk("t2.restart",  32'(d_count[0][4:0]), 32'd1);

    // Auto-rearm period of 32
    en = 2'b00; tick(1);
    en = 2'b01; pwm = 2'b01;
    done_n = 0;
    low_n  = 0;
    for (int k = 0; k < 64; k++) begin
      tick(1);
      done_n += int'(d_done[1][0]);
      low_n  += int'(!d_cnt_en[1][0]);
    end
    chk("t3.done_pulses", 32'(done_n), 32'd2);
    chk("t3.low_cycles",  32'(low_n),  32'd2);
    tick(1);
    chk("t3.rearm_cnt",   32'(d_count[1][4:0]), 32'd1);

    // Unconditional stop
    en = 2'b00; tick(1);
    en = 2'b01; pwm = 2'b00;
    tick(32);
    chk("t4.mode1_done", 32'(d_done[2]),   32'b01);
    chk("t4.mode1_en",   32'(d_cnt_en[2]), 32'b00);
    chk("t4.base_done",  32'(d_done[0]),   32'b00);
    chk("t4.base_en",    32'(d_cnt_en[0]), 32'b01);

    // Independent channels, abort at the terminal cycle
    en = 2'b00; tick(1);
    en = 2'b11; pwm = 2'b10;
    tick(32);
    chk("t5.done1",  32'(d_done[0]),   32'b10);
    chk("t5.cnt_en", 32'(d_cnt_en[0]), 32'b01);
    chk("t5.busy",   32'(d_busy[0]),   32'd1);
    chk("t5.count",  32'(d_count[0]),  32'd0);
    en = 2'b00; tick(1);
    en = 2'b11;
    tick(31);
    chk("t5.cnt1_max", 32'(d_count[0][9:5]), 32'd31);
    en = 2'b01;
    tick(1);
    chk("t5.abort_done", 32'(d_done[0]),      32'b00);
    chk("t5.abort_en",   32'(d_cnt_en[0]),    32'b01);
    chk("t5.abort_cnt1", 32'(d_count[0][9:5]), 32'd0);

    // Mid-run reset
    en = 2'b00; tick(1);
    en = 2'b01; pwm = 2'b00;
    tick(17);
    chk("t6.count17", 32'(d_count[0][4:0]), 32'd17);
    rst_n = 1'b0;
    tick(1);
    chk("t6.rst_cnt",  32'(d_count[0]),  32'd0);
    chk("t6.rst_en",   32'(d_cnt_en[0]), 32'd0);
    chk("t6.rst_done", 32'(d_done[0]),   32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("t6.resume", 32'(d_count[0][4:0]), 32'd1);

    // Limit flag toggling away from the terminal count
    en = 2'b11;
    for (int k = 0; k < 80; k++) begin
      pwm = 2'(k % 3);
      tick(1);
    end
    en = 2'b00;
    tick(2);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sweep_counter.md
Name: sweep_counter

Overview:
- Parametrised multi-axis sweep-enable counter for the tracker calibration FSM.
- One independent channel per servo axis (e.g. horizontal, vertical).
- While a channel's sweep enable is high, it asserts its counter-enable output and runs a terminal counter.
- The channel stops, and pulses DONE, when the terminal count is reached under the selected limit mode. Re-arm policy is selectable.

Parameters:
NCH, 2, number of independent axis channels
CW, 5, count width per channel in bits
MAXCNT, 31, terminal count value; must satisfy 0 < MAXCNT ≤ 2^CW−1
MODE, 0, 0 = stop at MAXCNT only if PWM_LIMIT is high (otherwise wrap); 1 = stop at MAXCNT unconditionally
REARM, 1, 0 = auto-restart the cycle after a stop while EN is held; 1 = after a stop, wait for EN low before restarting

Ports:
CLK  in  1  system clock, rising-edge
RST_N  in  1  synchronous active-low reset
EN  in  NCH  per-channel sweep enable from the FSM (bit i = channel i)
PWM_LIMIT  in  NCH  per-channel servo PWM limit-reached flag
CNT_EN  out  NCH  per-channel counter enable to the position counter (registered)
DONE  out  NCH  per-channel one-cycle pulse on terminal stop (registered)
COUNT  out  NCH*CW  packed current counts; channel i occupies bits [i*CW +: CW]
BUSY  out  1  OR of all CNT_EN bits (combinational from registers)

Behaviour:
- Reset: when RST_N is low at a CLK edge, every channel goes to IDLE with COUNT=0, CNT_EN=0, DONE=0; BUSY=0. Reset overrides all inputs, including mid-run.
- Channels are fully independent. No arbitration between channels.
- Per-channel FSM states: IDLE, RUN, STOP.
- EN=0 at any edge, in any state: next state IDLE, COUNT←0, CNT_EN←0, DONE←0. No DONE is generated on abort.
- IDLE with EN=1: next state RUN, CNT_EN←1, COUNT←1.
  - Latency: CNT_EN is high in the cycle after the first edge that samples EN=1.
- RUN with EN=1, terminal condition = (COUNT==MAXCNT) AND (PWM_LIMIT==1 OR MODE==1):
  - Terminal condition true: next state STOP, CNT_EN←0, COUNT←0, DONE←1.
  - Terminal condition false: CNT_EN←1, COUNT←COUNT+1. COUNT wraps MAXCNT→0, never reaching values above MAXCNT (relevant when MAXCNT < 2^CW−1).
- STOP with EN=1, CNT_EN←0, DONE←0:
  - REARM=1: remain in STOP until EN=0, which returns the channel to IDLE.
  - REARM=0: next state RUN, CNT_EN←1, COUNT←1. CNT_EN is low for exactly one cycle between runs.
- DONE is high for exactly one cycle per stop, aligned with the first cycle of CNT_EN=0.
- PWM_LIMIT is sampled only at COUNT==MAXCNT; it is ignored at all other counts.
- EN falling in the same cycle as the terminal condition: the EN=0 rule wins (IDLE, no DONE).
- Simultaneous terminal events on several channels produce DONE on each in the same cycle.
- MODE=0 with NCH=1, CW=5, MAXCNT=31, REARM=0 reproduces the legacy single-axis behaviour, except that an IDLE→RUN entry loads COUNT=1.

Test Plan:
(Unless noted: NCH=2, CW=5, MAXCNT=31, MODE=0, REARM=1.)
1. Reset, then EN=2'b01 held 40 cycles with PWM_LIMIT=0 → CNT_EN[0]=1 from cycle 1 onward, continuously; COUNT0 sequence 1..31,0,1,…; DONE stays 0; CNT_EN[1]=0; BUSY=1.
2. EN[0]=1 with PWM_LIMIT[0]=1 → at COUNT0=31 the next cycle shows CNT_EN[0]=0, DONE[0]=1 for one cycle, COUNT0=0. Channel stays stopped while EN[0]=1. EN[0] low one cycle then high → restarts with COUNT0=1.
3. REARM=0 with PWM_LIMIT[0]=1 held → repeating period of 32 cycles: CNT_EN[0] low exactly 1 cycle, DONE[0] pulses once per period.
4. MODE=1 with PWM_LIMIT=0 → stop and DONE at COUNT=31 regardless of the limit flag.
5. Both EN bits high, PWM_LIMIT=2'b10 → channel 1 stops at 31 with DONE[1]; channel 0 wraps and keeps running; BUSY stays 1. Drop EN[1] at COUNT1=31 in the same cycle as the limit → no DONE[1].
6. RST_N low for 1 cycle at COUNT0=17 mid-run → next cycle COUNT0=0, CNT_EN=0, DONE=0. With EN still high, the run restarts on the following edge with COUNT0=1.
